// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg : shared constants and types for the SPI mode-0 responder.
//   SPI_WIDTH      - default frame length in bits
//   SCLK_MIN_PHASE - minimum SCLK high/low phase, in clk cycles, that the
//                    responder can follow (the master models pace off this)
//   state_t        - responder frame state
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_WIDTH      = 16;
   localparam int SCLK_MIN_PHASE = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

endpackage

// File: rtl/spi_resp_if.sv
// ---------------------------------------------------------------------------
// spi_resp_if : host-side bus of the SPI responder.
//   tx_data  - response word for a following frame
//   wrt      - one-clk strobe, loads tx_data into the response buffer
//   rx_data  - last complete command received
//   rdy      - one-clk pulse, rx_data updated
//   frm_err  - one-clk pulse, frame ended with a bad bit count
//   busy     - high while a frame is in progress
// master modport is the host (bus model / bench); slave is spi_resp.
// ---------------------------------------------------------------------------
interface spi_resp_if #(
   parameter int WIDTH = spi_pkg::SPI_WIDTH
);

   logic [WIDTH-1:0] tx_data;
   logic             wrt;
   logic [WIDTH-1:0] rx_data;
   logic             rdy;
   logic             frm_err;
   logic             busy;

   modport master (
      output tx_data, wrt,
      input  rx_data, rdy, frm_err, busy
   );

   modport slave (
      input  tx_data, wrt,
      output rx_data, rdy, frm_err, busy
   );

endinterface

// File: rtl/spi_resp_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge : 3-flop synchroniser for an asynchronous input, with 1-clk
// edge pulses taken between the 2nd and 3rd flop.
//   clk, rst_n - system clock, async active-low reset
//   i_d        - asynchronous input
//   o_sync     - synchronised level (2nd flop)
//   o_rise     - 1-clk pulse on a synchronised 0->1
//   o_fall     - 1-clk pulse on a synchronised 1->0
// RST_VAL is the idle level of the input, so leaving reset with the input
// at idle produces no edge.
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] r_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ff <= {3{RST_VAL}};
      else        r_ff <= {r_ff[1:0], i_d};
   end

   assign o_sync = r_ff[1];
   assign o_rise =  r_ff[1] & ~r_ff[2];
   assign o_fall = ~r_ff[1] &  r_ff[2];

endmodule

// File: rtl/spi_resp.sv
// ---------------------------------------------------------------------------
// spi_resp : SPI mode-0 responder running in the system clk domain.
// Oversamples SS_n/SCLK/MOSI, captures a WIDTH-bit command (MSB first) and
// returns a preloaded WIDTH-bit response on MISO.
//   clk, rst_n - system clock, async active-low reset
//   SS_n       - slave select (active low, async)
//   SCLK       - serial clock (idles low, async)
//   MOSI       - serial data in, sampled on SCLK rise
//   MISO       - serial data out, shifted on SCLK fall; Z while SS_n high
//   hif        - host bus (tx_data/wrt in, rx_data/rdy/frm_err/busy out)
// ---------------------------------------------------------------------------
module spi_resp
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       SCLK,
   input  logic       MOSI,
   output wire        MISO,
   spi_resp_if.slave  hif
);

   // bit_cnt must reach WIDTH+1 so an overrun is distinguishable from WIDTH
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   logic w_ss_lvl, w_ss_rise, w_ss_fall;
   logic w_unused_sclk_lvl;  // only SCLK edges matter
   logic w_sclk_rise, w_sclk_fall;
   logic [1:0] r_mosi;

   sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (SS_n),
      .o_sync (w_ss_lvl),
      .o_rise (w_ss_rise),
      .o_fall (w_ss_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (SCLK),
      .o_sync (w_unused_sclk_lvl),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   // MOSI needs only the 2-flop stage; it lines up with the SCLK edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_mosi <= '0;
      else        r_mosi <= {r_mosi[0], MOSI};
   end

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_tx_buf, r_tx_shft, r_rx_shft, r_rx_data;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_rdy, r_frm_err, r_busy;
   logic             w_start, w_end, w_rx, w_tx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Frame end wins over a coincident SCLK edge: the edge is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_end       = 1'b0;
      w_rx        = 1'b0;
      w_tx        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ss_fall) begin
               w_start     = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_ss_rise) begin
               w_end       = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_rx = w_sclk_rise;
               // a fall before the first rise is spurious and must not shift
               w_tx = w_sclk_fall && (r_bit_cnt != '0);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_buf  <= '0;
         r_tx_shft <= '0;
         r_rx_shft <= '0;
         r_rx_data <= '0;
         r_bit_cnt <= '0;
         r_rdy     <= 1'b0;
         r_frm_err <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_rdy     <= 1'b0;
         r_frm_err <= 1'b0;
         // buffer write is independent of frame state; a running frame
         // keeps its own copy in tx_shft
         if (hif.wrt) r_tx_buf <= hif.tx_data;
         if (w_start) begin
            r_tx_shft <= hif.wrt ? hif.tx_data : r_tx_buf;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
         end
         if (w_rx) begin
            r_rx_shft <= {r_rx_shft[WIDTH-2:0], r_mosi[1]};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_tx) r_tx_shft <= {r_tx_shft[WIDTH-2:0], 1'b0};
         if (w_end) begin
            r_busy <= 1'b0;
            if (r_bit_cnt == CNT_FULL) begin
               r_rx_data <= r_rx_shft;
               r_rdy     <= 1'b1;
            end else begin
               r_frm_err <= 1'b1;
            end
         end
      end
   end

   assign MISO        = w_ss_lvl ? 1'bz : r_tx_shft[WIDTH-1];
   assign hif.rx_data = r_rx_data;
   assign hif.rdy     = r_rdy;
   assign hif.frm_err = r_frm_err;
   assign hif.busy    = r_busy;

endmodule

// File: tb/tb_spi_resp.sv
module tb_spi_resp;
   import spi_pkg::*;

   localparam int W    = SPI_WIDTH;
   localparam int HALF = 2 * SCLK_MIN_PHASE;  // 8 clk per phase -> SCLK = clk/16

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic SS_n  = 1'b1;
   logic SCLK  = 1'b0;
   logic MOSI  = 1'b0;
   wire  MISO;

   spi_resp_if #(.WIDTH(W)) hif ();

   spi_resp #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .MISO  (MISO),
      .hif   (hif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         err;
      logic [W-1:0] data;
   } exp_t;

   exp_t         exp_q[$];
   int           n_chk   = 0;
   int           n_err   = 0;
   logic [W-1:0] last_rx = '0;
   logic [W-1:0] resp;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_buf(input logic [W-1:0] d);
      hif.tx_data = d;
      hif.wrt     = 1'b1;
      clk_wait(1);
      hif.wrt     = 1'b0;
   endtask

   // Mode-0 master. rst_at >= 0 pulls rst_n before that bit and abandons the frame.
   task automatic spi_frame(input logic [W-1:0] cmd, input int nbits, input int rst_at,
                            output logic [W-1:0] rsp);
      logic [W-1:0] sh;
      sh  = cmd;
      rsp = '0;
      if (rst_at < 0) begin
         if (nbits == W) begin
            exp_q.push_back({1'b0, cmd});
            last_rx = cmd;
         end else begin
            exp_q.push_back({1'b1, last_rx});
         end
      end
      SS_n = 1'b0;
      MOSI = sh[W-1];
      clk_wait(HALF);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            clk_wait(2);
            SS_n = 1'b1;
            SCLK = 1'b0;
            MOSI = 1'b0;
            clk_wait(4);
            chk("abort_busy", {31'd0, hif.busy}, 0);
            chk("abort_rx", {16'd0, hif.rx_data}, 0);
            last_rx = '0;
            rst_n   = 1'b1;
            clk_wait(HALF);
            return;
         end
         MOSI = sh[W-1];
         sh   = sh << 1;
         clk_wait(HALF);
         SCLK = 1'b1;
         rsp  = {rsp[W-2:0], MISO};
         if (i == 1) chk("busy_mid", {31'd0, hif.busy}, 1);
         clk_wait(HALF);
         SCLK = 1'b0;
      end
      clk_wait(HALF);
      SS_n = 1'b1;
      clk_wait(2);
      @(negedge clk);
      chk("lat_early", {30'd0, hif.rdy, hif.frm_err}, 0);
      @(negedge clk);
      chk("lat_rdy", {31'd0, hif.rdy}, {31'd0, nbits == W});
      chk("lat_err", {31'd0, hif.frm_err}, {31'd0, nbits != W});
      @(negedge clk);
      chk("busy_end", {31'd0, hif.busy}, 0);
      clk_wait(HALF);
   endtask

   // scoreboard: every rdy/frm_err pulse must match the oldest expected frame
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (hif.rdy || hif.frm_err)) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexp", {30'd0, hif.rdy, hif.frm_err}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_rdy", {31'd0, hif.rdy}, {31'd0, !e.err});
            chk("sb_err", {31'd0, hif.frm_err}, {31'd0, e.err});
            chk("sb_rx", {16'd0, hif.rx_data}, {16'd0, e.data});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin
      hif.wrt     = 1'b0;
      hif.tx_data = '0;
      clk_wait(3);
      rst_n = 1'b1;
      clk_wait(3);
      chk("rst_rx", {16'd0, hif.rx_data}, 0);
      chk("rst_rdy", {31'd0, hif.rdy}, 0);
      chk("rst_err", {31'd0, hif.frm_err}, 0);
      chk("rst_busy", {31'd0, hif.busy}, 0);

      wr_buf(16'hA5C3);
      clk_wait(4);
      chk("wrt_idle_busy", {31'd0, hif.busy}, 0);

      spi_frame(16'h1800, W, -1, resp);
      chk("resp_a5c3", {16'd0, resp}, 32'hA5C3);

      spi_frame(16'h0000, W, -1, resp);
      chk("resp_rep0", {16'd0, resp}, 32'hA5C3);
      spi_frame(16'hFFFF, W, -1, resp);
      chk("resp_rep1", {16'd0, resp}, 32'hA5C3);
      chk("rx_ffff", {16'd0, hif.rx_data}, 32'hFFFF);

      wr_buf(16'h1234);
      fork
         spi_frame(16'h5555, W, -1, resp);
         begin
            clk_wait(60);
            wr_buf(16'h0F0F);
         end
      join
      chk("resp_old_buf", {16'd0, resp}, 32'h1234);
      spi_frame(16'hAAAA, W, -1, resp);
      chk("resp_new_buf", {16'd0, resp}, 32'h0F0F);

      spi_frame(16'h1357, 12, -1, resp);
      chk("short_rx_hold", {16'd0, hif.rx_data}, 32'hAAAA);
      spi_frame(16'hBEEF, 17, -1, resp);
      chk("over_rx_hold", {16'd0, hif.rx_data}, 32'hAAAA);

      spi_frame(16'h00FF, W, 8, resp);
      spi_frame(16'h2800, W, -1, resp);
      chk("resp_after_rst", {16'd0, resp}, 32'h0000);
      chk("rx_2800", {16'd0, hif.rx_data}, 32'h2800);

      clk_wait(10);
      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
